// File: rtl/icache_pkg.sv
// ============================================================================
// Module   : icache_pkg
// Brief    : Shared types, widths and PC-split helpers for the instruction cache.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package icache_pkg;

  localparam int BLOCK_BITS  = 128;
  localparam int WORD_BITS   = 32;
  localparam int OFFSET_BITS = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_t;

  function automatic logic [31:0] pc_index(input logic [31:0] pc, input int unsigned index_bits);
    return (pc >> OFFSET_BITS) & ((32'd1 << index_bits) - 32'd1);
  endfunction

  function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int unsigned addr_bits,
                                         input int unsigned index_bits);
    return (pc >> (OFFSET_BITS + index_bits)) &
           ((32'd1 << (addr_bits - OFFSET_BITS - index_bits)) - 32'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/icache_line_store.sv
// ============================================================================
// Module   : icache_line_store
// Brief    : Valid/tag/data arrays; one write port, combinational hit and word read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_line_store
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = 3
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  i_wr_en,
  input  logic [INDEX_BITS-1:0] i_wr_index,
  input  logic [TAG_BITS-1:0]   i_wr_tag,
  input  logic [BLOCK_BITS-1:0] i_wr_data,
  input  logic [INDEX_BITS-1:0] i_rd_index,
  input  logic [TAG_BITS-1:0]   i_rd_tag,
  input  logic [1:0]            i_rd_word,
  output logic                  o_hit,
  output logic [WORD_BITS-1:0]  o_rd_data
);

  localparam int c_lines = 2 ** INDEX_BITS;

  logic [c_lines-1:0]    r_valid;
  logic [TAG_BITS-1:0]   r_tag   [c_lines];
  logic [BLOCK_BITS-1:0] r_data  [c_lines];
  logic [BLOCK_BITS-1:0] w_line;
  logic [WORD_BITS-1:0]  w_word  [4];

  // Only the valid bits need a reset; stale tag/data are masked by valid.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (i_wr_en) begin
      r_tag[i_wr_index]  <= i_wr_tag;
      r_data[i_wr_index] <= i_wr_data;
    end
  end

  assign w_line = r_data[i_rd_index];
  assign o_hit  = r_valid[i_rd_index] && (r_tag[i_rd_index] == i_rd_tag);

  generate
    for (genvar w = 0; w < 4; w++) begin : g_word
      assign w_word[w] = w_line[WORD_BITS*w +: WORD_BITS];
    end
  endgenerate

  assign o_rd_data = w_word[i_rd_word];

endmodule

`default_nettype wire

// File: rtl/icache_ctrl.sv
// ============================================================================
// Module   : icache_ctrl
// Brief    : Direct-mapped instruction cache controller with block refill FSM.
//            Define ICACHE_STATS_EN to add saturating hit/miss counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_ctrl
  import icache_pkg::*;
#(
  parameter int ADDR_BITS  = 10,
  parameter int INDEX_BITS = 3
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [31:0]             PC,
  output logic [31:0]             INSTRUCTION,
  output logic                    BUSYWAIT,
  output logic                    mem_read,
  output logic [ADDR_BITS-5:0]    mem_address,
  input  logic [BLOCK_BITS-1:0]   mem_readdata,
  input  logic                    mem_ready
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]             hit_count,
  output logic [15:0]             miss_count
`endif
);

  localparam int c_tag_bits = ADDR_BITS - OFFSET_BITS - INDEX_BITS;

  state_t                  r_state;
  logic                    r_mem_read;
  logic [BLOCK_BITS-1:0]   r_fill;
  logic [INDEX_BITS-1:0]   r_index;
  logic [c_tag_bits-1:0]   r_tag;

  logic [INDEX_BITS-1:0]   w_index;
  logic [c_tag_bits-1:0]   w_tag;
  logic                    w_hit;
  logic [WORD_BITS-1:0]    w_word;

  assign w_index = INDEX_BITS'(pc_index(PC, INDEX_BITS));
  assign w_tag   = c_tag_bits'(pc_tag(PC, ADDR_BITS, INDEX_BITS));

  icache_line_store #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (c_tag_bits)
  ) u_line_store (
    .CLK        (CLK),
    .RESET      (RESET),
    .i_wr_en    (r_state == UPDATE),
    .i_wr_index (r_index),
    .i_wr_tag   (r_tag),
    .i_wr_data  (r_fill),
    .i_rd_index (w_index),
    .i_rd_tag   (w_tag),
    .i_rd_word  (PC[3:2]),
    .o_hit      (w_hit),
    .o_rd_data  (w_word)
  );

  // Index/tag are captured on miss detection so the fill target cannot move.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state    <= IDLE;
      r_mem_read <= 1'b0;
      r_fill     <= '0;
      r_index    <= '0;
      r_tag      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_hit) begin
            r_state    <= MEM_READ;
            r_mem_read <= 1'b1;
            r_index    <= w_index;
            r_tag      <= w_tag;
          end
        end
        MEM_READ: begin
          if (mem_ready) begin
            r_fill     <= mem_readdata;
            r_mem_read <= 1'b0;
            r_state    <= UPDATE;
          end
        end
        UPDATE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state    <= IDLE;
          r_mem_read <= 1'b0;
        end
      endcase
    end
  end

  assign BUSYWAIT    = (r_state != IDLE) || !w_hit;
  assign INSTRUCTION = BUSYWAIT ? 32'h0 : w_word;
  assign mem_read    = r_mem_read;
  assign mem_address = {r_tag, r_index};

`ifdef ICACHE_STATS_EN
  logic [15:0] r_hit_count;
  logic [15:0] r_miss_count;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (r_state == IDLE) begin
      if (w_hit && (r_hit_count != 16'hFFFF)) begin
        r_hit_count <= r_hit_count + 16'd1;
      end
      if (!w_hit && (r_miss_count != 16'hFFFF)) begin
        r_miss_count <= r_miss_count + 16'd1;
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_icache_ctrl.sv
// ============================================================================
// Module   : tb_icache_ctrl
// Brief    : Directed scoreboard bench for icache_ctrl (optional ICACHE_STATS_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icache_ctrl;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic [31:0]   PC = 32'h0;
  logic [31:0]   INSTRUCTION;
  logic          BUSYWAIT;
  logic          mem_read;
  logic [5:0]    mem_address;
  logic [127:0]  mem_readdata = '0;
  logic          mem_ready = 1'b0;
`ifdef ICACHE_STATS_EN
  logic [15:0]   hit_count;
  logic [15:0]   miss_count;
`endif

  int            n_vec = 0;
  int            n_err = 0;
  int            exp_hits = 0;
  logic [31:0]   sb[$];

  always #5 CLK = ~CLK;

  icache_ctrl dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .PC           (PC),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_ready    (mem_ready)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  // Memory contents: word w of block b is (b << 8) | w.
  function automatic logic [127:0] block_of(input logic [5:0] ba);
    logic [127:0] blk;
    for (int w = 0; w < 4; w++) begin
      blk[32*w +: 32] = ({26'd0, ba} << 8) | 32'(w);
    end
    return blk;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic [31:0] pc, input bit miss, input int lat, input bit stale);
    logic [5:0]   ba;
    logic [127:0] blk;
    logic [31:0]  exp;
    ba  = pc[9:4];
    blk = block_of(ba);
    exp = blk[32*pc[3:2] +: 32];
    @(negedge CLK);
    PC = pc;
    sb.push_back(exp);
    #1;
    if (miss) begin
      chk("miss_busy", 32'(BUSYWAIT), 32'd1);
      chk("miss_instr", INSTRUCTION, 32'd0);
      if (stale) begin
        mem_ready    = 1'b1;
        mem_readdata = {4{32'hDEADBEEF}};
      end
      @(negedge CLK);
      mem_ready    = 1'b0;
      mem_readdata = '0;
      #1;
      for (int i = 0; i < lat; i++) begin
        chk("rd_req", 32'(mem_read), 32'd1);
        chk("rd_addr", 32'(mem_address), 32'(ba));
        chk("rd_busy", 32'(BUSYWAIT), 32'd1);
        if (i == lat - 1) begin
          mem_ready    = 1'b1;
          mem_readdata = blk;
        end
        @(negedge CLK);
        mem_ready    = 1'b0;
        mem_readdata = '0;
        #1;
      end
      chk("upd_req", 32'(mem_read), 32'd0);
      chk("upd_busy", 32'(BUSYWAIT), 32'd1);
      @(negedge CLK);
      #1;
    end
    chk("hit_busy", 32'(BUSYWAIT), 32'd0);
    chk("hit_req", 32'(mem_read), 32'd0);
    chk("instr", INSTRUCTION, sb.pop_front());
    exp_hits++;
  endtask

  initial begin
    // Reset state: everything misses, no request.
    #12;
    chk("rst_req", 32'(mem_read), 32'd0);
    chk("rst_busy", 32'(BUSYWAIT), 32'd1);
    chk("rst_instr", INSTRUCTION, 32'd0);
    @(posedge CLK);
    #2 RESET = 1'b1;

    // Cold miss, then spatial hits
    fetch(32'h000, 1'b1, 3, 1'b0);
    fetch(32'h004, 1'b0, 0, 1'b0);
    fetch(32'h008, 1'b0, 0, 1'b0);
    fetch(32'h00C, 1'b0, 0, 1'b0);

    // Conflict eviction on index 0
    fetch(32'h080, 1'b1, 2, 1'b0);
`ifdef ICACHE_STATS_EN
    @(negedge CLK);
    #1;
    chk("hit_count", 32'(hit_count), 32'(exp_hits));
    chk("miss_count", 32'(miss_count), 32'd2);
    exp_hits++;
`endif
    fetch(32'h000, 1'b1, 1, 1'b0);
    fetch(32'h084, 1'b1, 1, 1'b0);

    // Slow memory on index 1
    fetch(32'h010, 1'b1, 20, 1'b0);
    fetch(32'h01C, 1'b0, 0, 1'b0);
    fetch(32'h088, 1'b0, 0, 1'b0);

`ifdef ICACHE_STATS_EN
    repeat (65600) @(negedge CLK);
    #1;
    chk("hit_sat", 32'(hit_count), 32'hFFFF);
`endif

    // Reset in the middle of a fill
    @(negedge CLK);
    PC = 32'h100;
    #1;
    chk("mf_busy", 32'(BUSYWAIT), 32'd1);
    @(negedge CLK);
    #1;
    chk("mf_req", 32'(mem_read), 32'd1);
    #2 RESET = 1'b0;
    #1;
    chk("mf_rst_req", 32'(mem_read), 32'd0);
    chk("mf_rst_busy", 32'(BUSYWAIT), 32'd1);
    chk("mf_rst_instr", INSTRUCTION, 32'd0);
    PC = 32'h000;
    @(posedge CLK);
    #2 RESET = 1'b1;
`ifdef ICACHE_STATS_EN
    chk("rst_hit_count", 32'(hit_count), 32'd0);
`endif
    fetch(32'h000, 1'b1, 2, 1'b1);
    fetch(32'h010, 1'b1, 1, 1'b0);
    fetch(32'h004, 1'b0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
